// File: rtl/button_entry.sv
// Operand-entry front end for the ALU demo board.
// Two raw pushbuttons are synchronised and debounced. "inc" bumps the field
// being edited and "next" steps A -> B -> opcode -> result -> A. select
// tells the display which field to show, and result_valid pulses once on
// entry to the result phase.
module button_entry #(
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_inc_raw,
  input  logic       btn_next_raw,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic [2:0] opCodeA,
  output logic [1:0] select,
  output logic       result_valid
);

  localparam int             CW           = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST     = CW'(DEBOUNCE_CYCLES - 1);
  // Raw pin level of a button that is not being pressed.
  localparam logic           RAW_RELEASED = BTN_ACTIVE_LOW;

  // Encoding doubles as the display select code.
  typedef enum logic [1:0] {
    ENTER_A     = 2'b00,
    ENTER_B     = 2'b01,
    ENTER_OP    = 2'b10,
    SHOW_RESULT = 2'b11
  } state_t;

  // Button index 0 = inc, 1 = next.
  logic [1:0]    raw;
  logic [1:0]    sync1, sync2;
  logic [1:0]    level;      // synchronised, 1 = pressed
  logic [1:0]    db;         // debounced level, 1 = pressed
  logic [1:0]    db_q;       // debounced level one cycle late
  logic [1:0]    press;      // one-cycle press events
  logic [CW-1:0] cnt [2];

  state_t     state, state_n;
  logic [3:0] a_n, b_n;
  logic [2:0] op_n;
  logic       rv_n;

  assign raw   = {btn_next_raw, btn_inc_raw};
  assign level = sync2 ^ {2{RAW_RELEASED}};
  assign press = db & ~db_q;

  // Two-flop synchroniser; resets to the released pin level.
  // NOTE: every flop is written with <= so all of them sample the
  // pre-edge values; blocking assignments here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= {2{RAW_RELEASED}};
      sync2 <= {2{RAW_RELEASED}};
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive
  // cycles of disagreement with the current debounced level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db   <= '0;
      db_q <= '0;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      db_q <= db;
      for (int i = 0; i < 2; i++) begin
        if (level[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          db[i]  <= level[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Next-state and field updates; next beats a simultaneous inc.
  // NOTE: every output of this block gets a default first so no path
  // leaves a variable unassigned, which would infer a latch.
  always_comb begin
    state_n = state;
    a_n     = A;
    b_n     = B;
    op_n    = opCodeA;
    rv_n    = 1'b0;
    if (press[1]) begin
      unique case (state)
        ENTER_A:     state_n = ENTER_B;
        ENTER_B:     state_n = ENTER_OP;
        ENTER_OP:    state_n = SHOW_RESULT;
        SHOW_RESULT: state_n = ENTER_A;
        default:     state_n = ENTER_A;
      endcase
      rv_n = (state == ENTER_OP);
    end else if (press[0]) begin
      unique case (state)
        ENTER_A:     a_n  = A + 4'd1;
        ENTER_B:     b_n  = B + 4'd1;
        ENTER_OP:    op_n = opCodeA + 3'd1;
        SHOW_RESULT: ;
        default:     ;
      endcase
    end
  end

  // State, operand registers and registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ENTER_A;
      A            <= '0;
      B            <= '0;
      opCodeA      <= '0;
      select       <= 2'b00;
      result_valid <= 1'b0;
    end else begin
      state        <= state_n;
      A            <= a_n;
      B            <= b_n;
      opCodeA      <= op_n;
      select       <= state_n;
      result_valid <= rv_n;
    end
  end

endmodule

// File: tb/tb_button_entry.sv
// Bench for button_entry with a 4-cycle debounce and active-low buttons.
// A behavioural model predicts every output each cycle, and directed steps
// add fixed expectations at the interesting points.
module tb_button_entry;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_inc_raw = 1'b1;
  logic       btn_next_raw = 1'b1;
  logic [3:0] A, B;
  logic [2:0] opCodeA;
  logic [1:0] select;
  logic       result_valid;

  int n_checks = 0;
  int n_fail   = 0;
  int rv_seen  = 0;

  button_entry #(.DEBOUNCE_CYCLES(D), .BTN_ACTIVE_LOW(1'b1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_inc_raw  (btn_inc_raw),
    .btn_next_raw (btn_next_raw),
    .A            (A),
    .B            (B),
    .opCodeA      (opCodeA),
    .select       (select),
    .result_valid (result_valid)
  );

  always #5 clk = ~clk;

  // Reference model: a button level is accepted once the synchronised
  // level (two samples late) has disagreed with the accepted level for D
  // consecutive samples. A rising accepted level is a press, which acts
  // on the fields at the following edge.
  int         ph, ma, mb, mop, mrv;
  bit [D+1:0] hist [2];
  bit         mdb  [2];
  bit         pend [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph = 0; ma = 0; mb = 0; mop = 0; mrv = 0;
      for (int i = 0; i < 2; i++) begin
        hist[i] = '0; mdb[i] = 1'b0; pend[i] = 1'b0;
      end
    end else begin
      mrv = 0;
      if (pend[1]) begin
        mrv = (ph == 2) ? 1 : 0;
        ph  = (ph + 1) % 4;
      end else if (pend[0]) begin
        if (ph == 0) ma = (ma + 1) % 16;
        else if (ph == 1) mb = (mb + 1) % 16;
        else if (ph == 2) mop = (mop + 1) % 8;
      end
      hist[0] = {hist[0][D:0], ~btn_inc_raw};
      hist[1] = {hist[1][D:0], ~btn_next_raw};
      for (int i = 0; i < 2; i++) begin
        bit stable;
        stable  = 1'b1;
        pend[i] = 1'b0;
        for (int j = 2; j <= D + 1; j++)
          if (hist[i][j] == mdb[i]) stable = 1'b0;
        if (stable) begin
          mdb[i]  = ~mdb[i];
          pend[i] = mdb[i];
        end
      end
    end
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge and compare all outputs to the model.
  task automatic tick();
    @(negedge clk);
    check("A", 8'(A), 8'(ma));
    check("B", 8'(B), 8'(mb));
    check("opCodeA", 8'(opCodeA), 8'(mop));
    check("select", 8'(select), 8'(ph));
    check("result_valid", 8'(result_valid), 8'(mrv));
    if (result_valid === 1'b1) rv_seen++;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  // Press the chosen buttons together for hold cycles, then release.
  task automatic press(input bit inc, input bit nxt);
    if (inc) btn_inc_raw = 1'b0;
    if (nxt) btn_next_raw = 1'b0;
    run(6 + $urandom_range(0, 3));
    btn_inc_raw  = 1'b1;
    btn_next_raw = 1'b1;
    run(9 + $urandom_range(0, 3));
  endtask

  initial begin
    // 1. Reset held while the buttons bounce.
    for (int k = 0; k < 8; k++) begin
      btn_inc_raw  = 1'($urandom_range(0, 1));
      btn_next_raw = 1'($urandom_range(0, 1));
      tick();
      check("rst_A", 8'(A), 8'd0);
      check("rst_select", 8'(select), 8'd0);
      check("rst_rv", 8'(result_valid), 8'd0);
    end
    btn_inc_raw  = 1'b1;
    btn_next_raw = 1'b1;
    tick();
    rst_n = 1'b1;
    run(3);
    btn_inc_raw = 1'b0;
    run(3);
    btn_inc_raw = 1'b1;
    run(8);
    check("post_rst_glitch_A", 8'(A), 8'd0);

    // 2. Debounce: short glitch ignored, long press counted once.
    btn_inc_raw = 1'b0;
    run(3);
    btn_inc_raw = 1'b1;
    run(8);
    check("glitch_A", 8'(A), 8'd0);
    btn_inc_raw = 1'b0;
    run(10);
    check("long_press_A", 8'(A), 8'd1);
    btn_inc_raw = 1'b1;
    run(10);
    check("release_A", 8'(A), 8'd1);

    // 3. Entry with wrap-around of A and opCodeA.
    repeat (16) press(1'b1, 1'b0);
    check("wrap_A", 8'(A), 8'd1);
    press(1'b0, 1'b1);
    repeat (3) press(1'b1, 1'b0);
    check("sel_B", 8'(select), 8'd1);
    check("B3", 8'(B), 8'd3);
    press(1'b0, 1'b1);
    repeat (9) press(1'b1, 1'b0);
    check("sel_op", 8'(select), 8'd2);
    check("wrap_op", 8'(opCodeA), 8'd1);
    rv_seen = 0;
    press(1'b0, 1'b1);
    check("sel_result", 8'(select), 8'd3);
    check("rv_pulses", 8'(rv_seen), 8'd1);

    // 4. Result phase ignores inc; next returns to A without a pulse.
    repeat (2) press(1'b1, 1'b0);
    check("res_A", 8'(A), 8'd1);
    check("res_B", 8'(B), 8'd3);
    check("res_op", 8'(opCodeA), 8'd1);
    rv_seen = 0;
    press(1'b0, 1'b1);
    check("lap_select", 8'(select), 8'd0);
    check("lap_rv", 8'(rv_seen), 8'd0);
    check("lap_A", 8'(A), 8'd1);

    // 5. Both buttons together: next wins.
    press(1'b0, 1'b1);
    press(1'b1, 1'b1);
    check("both_select", 8'(select), 8'd2);
    check("both_B", 8'(B), 8'd3);
    check("both_op", 8'(opCodeA), 8'd1);

    // 6. Reset in ENTER_OP with A=5 while next is held.
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    repeat (4) press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    check("pre_rst_A", 8'(A), 8'd5);
    check("pre_rst_select", 8'(select), 8'd2);
    btn_next_raw = 1'b0;
    run(2);
    rst_n = 1'b0;
    tick();
    check("mid_rst_A", 8'(A), 8'd0);
    check("mid_rst_op", 8'(opCodeA), 8'd0);
    check("mid_rst_select", 8'(select), 8'd0);
    rst_n = 1'b1;
    run(10);
    btn_next_raw = 1'b1;
    run(10);
    check("held_next_select", 8'(select), 8'd1);
    check("held_next_A", 8'(A), 8'd0);

    // Random bouncing on both buttons, followed by the model.
    for (int k = 0; k < 60; k++) begin
      btn_inc_raw  = 1'($urandom_range(0, 1));
      btn_next_raw = 1'($urandom_range(0, 1));
      run($urandom_range(1, 9));
    end
    btn_inc_raw  = 1'b1;
    btn_next_raw = 1'b1;
    run(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
